// File: rtl/ft_cmd_decoder.sv
// Parses 'W'/'R' command packets from the FT245 RX FIFO into register-bus cycles and returns
// read responses to the TX FIFO. Define FT_CMD_WRITE_ACK_EN to also acknowledge writes ('A', addr).
module ft_cmd_decoder #(
  parameter int TIMEOUT = 65535,
  parameter int AW      = 8,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_rdata,
  input  logic          rx_rempty,
  output logic          rx_rinc,
  output logic [7:0]    tx_wdata,
  input  logic          tx_wfull,
  output logic          tx_winc,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  output logic          reg_we,
  output logic          reg_re,
  input  logic [DW-1:0] reg_rdata,
  output logic          busy,
  output logic [7:0]    err_count
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    OP_WR    = 8'h57;
  localparam logic [7:0]    OP_RD    = 8'h52;
  localparam logic [7:0]    OP_ACK   = 8'h41;

  typedef enum logic [3:0] {
    S_IDLE, S_GET_ADDR, S_GET_DHI, S_GET_DLO,
    S_EXEC_WR, S_EXEC_RD, S_RD_WAIT, S_TX, S_ACK_0, S_ACK_1
  } state_t;

  state_t        state, state_nxt;
  logic          op_wr;
  logic [TW-1:0] tmo_cnt;
  logic [DW-1:0] resp;
  logic [1:0]    tx_idx;
  logic          in_get, tmo_hit, bad_op;

  assign busy = (state != S_IDLE);

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    rx_rinc   = 1'b0;
    tx_winc   = 1'b0;
    tx_wdata  = 8'h00;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    in_get    = 1'b0;
    tmo_hit   = 1'b0;
    bad_op    = 1'b0;
    case (state)
      S_IDLE: begin
        rx_rinc = ~rx_rempty;
        if (rx_rinc) begin
          if (rx_rdata == OP_WR || rx_rdata == OP_RD) state_nxt = S_GET_ADDR;
          else                                        bad_op    = 1'b1;
        end
      end
      S_GET_ADDR: begin
        in_get  = 1'b1;
        rx_rinc = ~rx_rempty;
        if (rx_rinc) state_nxt = op_wr ? S_GET_DHI : S_EXEC_RD;
      end
      S_GET_DHI: begin
        in_get  = 1'b1;
        rx_rinc = ~rx_rempty;
        if (rx_rinc) state_nxt = S_GET_DLO;
      end
      S_GET_DLO: begin
        in_get  = 1'b1;
        rx_rinc = ~rx_rempty;
        if (rx_rinc) state_nxt = S_EXEC_WR;
      end
      S_EXEC_WR: begin
        reg_we = 1'b1;
`ifdef FT_CMD_WRITE_ACK_EN
        state_nxt = S_ACK_0;
`else
        state_nxt = S_IDLE;
`endif
      end
      S_EXEC_RD: begin
        reg_re    = 1'b1;
        state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: state_nxt = S_TX;
      S_TX: begin
        tx_winc = ~tx_wfull;
        case (tx_idx)
          2'd0:    tx_wdata = OP_RD;
          2'd1:    tx_wdata = 8'(reg_addr);
          2'd2:    tx_wdata = resp[15:8];
          default: tx_wdata = resp[7:0];
        endcase
        if (tx_winc && tx_idx == 2'd3) state_nxt = S_IDLE;
      end
`ifdef FT_CMD_WRITE_ACK_EN
      S_ACK_0: begin
        tx_winc  = ~tx_wfull;
        tx_wdata = OP_ACK;
        if (tx_winc) state_nxt = S_ACK_1;
      end
      S_ACK_1: begin
        tx_winc  = ~tx_wfull;
        tx_wdata = 8'(reg_addr);
        if (tx_winc) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
    // A stalled partial packet is abandoned; the abort wins over the packet's own transition.
    if (in_get && rx_rempty && tmo_cnt == TMO_LAST) begin
      tmo_hit   = 1'b1;
      state_nxt = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_wr     <= 1'b0;
      tmo_cnt   <= '0;
      err_count <= 8'h00;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      state <= state_nxt;
      if ((bad_op || tmo_hit) && err_count != 8'hFF) err_count <= err_count + 8'h01;
      if (in_get && rx_rempty && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      else                                 tmo_cnt <= '0;
      if (rx_rinc) begin
        case (state)
          S_IDLE:     op_wr           <= (rx_rdata == OP_WR);
          S_GET_ADDR: reg_addr        <= rx_rdata[AW-1:0];
          S_GET_DHI:  reg_wdata[15:8] <= rx_rdata;
          S_GET_DLO:  reg_wdata[7:0]  <= rx_rdata;
          default:    ;
        endcase
      end
    end
  end

  // NOTE: response data and byte index need no reset; both are written in RD_WAIT before TX reads them.
  always_ff @(posedge clk) begin
    if (state == S_RD_WAIT) begin
      resp   <= reg_rdata;
      tx_idx <= 2'd0;
    end else if (state == S_TX && tx_winc) begin
      tx_idx <= tx_idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_ft_cmd_decoder.sv
// Self-checking bench for ft_cmd_decoder: FIFO/register-file models plus a packet-level reference
// model; honours FT_CMD_WRITE_ACK_EN when it is defined for the build.
module tb_ft_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_rdata = 8'h00;
  logic        rx_rempty = 1'b1;
  logic        rx_rinc;
  logic [7:0]  tx_wdata;
  logic        tx_wfull = 1'b0;
  logic        tx_winc;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we, reg_re;
  logic [15:0] reg_rdata = 16'h0000;
  logic        busy;
  logic [7:0]  err_count;

  ft_cmd_decoder #(.TIMEOUT(16), .AW(8), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .rx_rdata(rx_rdata), .rx_rempty(rx_rempty), .rx_rinc(rx_rinc),
    .tx_wdata(tx_wdata), .tx_wfull(tx_wfull), .tx_winc(tx_winc),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .err_count(err_count)
  );

  always #10 clk = ~clk;

  logic [7:0]  rxq[$];
  logic [7:0]  tx_obs[$], rd_obs[$];
  logic [23:0] wr_obs[$];
  int          pop_cyc[$], we_cyc[$], re_cyc[$], tx_cyc[$];
  logic [15:0] mem [256];
  int          cyc, stall_at, stall_cnt, bad_push, bad_pop, exp_err;
  bit          pop_pending, re_prev, gap_en, full_en;
  logic [7:0]  re_addr;
  int          n_checks, n_fail;
  event        sampled;

  function automatic string s8(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic string s24(input logic [23:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%06h ", q[i])};
    return s;
  endfunction

  // FIFO and register-file models: inputs change on the falling edge, outputs are sampled mid-low-phase.
  initial begin
    forever begin
      @(negedge clk);
      if (pop_pending) void'(rxq.pop_front());
      rx_rempty = (rxq.size() == 0) || (gap_en && ($urandom_range(3) == 0));
      rx_rdata  = rx_rempty ? 8'($urandom) : rxq[0];
      if (stall_cnt > 0) begin
        tx_wfull = 1'b1;
        stall_cnt--;
      end else begin
        tx_wfull = full_en && ($urandom_range(3) == 0);
      end
      reg_rdata = re_prev ? mem[re_addr] : 16'($urandom);
      #5;
      cyc++;
      pop_pending = (rx_rinc === 1'b1);
      if (rx_rinc === 1'b1) begin
        pop_cyc.push_back(cyc);
        if (rx_rempty) bad_pop++;
      end
      if (reg_we === 1'b1) begin
        wr_obs.push_back({reg_addr, reg_wdata});
        we_cyc.push_back(cyc);
        mem[reg_addr] = reg_wdata;
      end
      re_prev = (reg_re === 1'b1);
      if (reg_re === 1'b1) begin
        rd_obs.push_back(reg_addr);
        re_cyc.push_back(cyc);
        re_addr = reg_addr;
      end
      if (tx_winc === 1'b1) begin
        if (tx_wfull) bad_push++;
        tx_obs.push_back(tx_wdata);
        tx_cyc.push_back(cyc);
        if (stall_at != 0 && tx_obs.size() == stall_at) stall_cnt = 5;
      end
      -> sampled;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(sampled);
  endtask

  task automatic clear_obs();
    tx_obs.delete(); rd_obs.delete(); wr_obs.delete();
    pop_cyc.delete(); we_cyc.delete(); re_cyc.delete(); tx_cyc.delete();
  endtask

  task automatic send(input logic [7:0] b[$]);
    foreach (b[i]) rxq.push_back(b[i]);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(sampled);
      if (rxq.size() == 0 && busy === 1'b0 && !pop_pending) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drained(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(sampled);
      if (rxq.size() == 0 && !pop_pending) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] got [8];
    string      nm  [8];
    got = '{8'(busy), err_count, 8'(rx_rinc), 8'(tx_winc), 8'(reg_we), 8'(reg_re), reg_addr, reg_wdata[7:0]};
    nm  = '{"busy", "err_count", "rx_rinc", "tx_winc", "reg_we", "reg_re", "reg_addr", "reg_wdata_lo"};
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_%s: got %02h expected 00", nm[i], got[i]);
      end
    end
    n_checks++;
    if (reg_wdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_reg_wdata: got %04h expected 0000", reg_wdata);
    end
  endtask

  task automatic test_write();
    bit    ok;
    int    burst, lat;
    string exp_tx;
`ifdef FT_CMD_WRITE_ACK_EN
    exp_tx = "41 10 ";
`else
    exp_tx = "";
`endif
    clear_obs();
    send('{8'h57, 8'h10, 8'hAB, 8'hCD});
    wait_idle(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL write_idle: got busy expected idle"); end
    n_checks++;
    if (s24(wr_obs) != "10abcd ") begin
      n_fail++; $display("FAIL write_bus: got '%s' expected '10abcd '", s24(wr_obs));
    end
    burst = (pop_cyc.size() == 4) ? pop_cyc[3] - pop_cyc[0] : -1;
    lat   = (pop_cyc.size() == 4 && we_cyc.size() == 1) ? we_cyc[0] - pop_cyc[3] : -1;
    n_checks++;
    if (burst != 3) begin n_fail++; $display("FAIL write_pop_burst: got %0d expected 3", burst); end
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL write_latency: got %0d expected 1", lat); end
    n_checks++;
    if (s8(tx_obs) != exp_tx) begin
      n_fail++; $display("FAIL write_tx: got '%s' expected '%s'", s8(tx_obs), exp_tx);
    end
  endtask

  task automatic test_read();
    bit ok;
    int re_lat, tx_lat;
    clear_obs();
    mem[8'h22] = 16'h1234;
    send('{8'h52, 8'h22});
    wait_idle(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL read_idle: got busy expected idle"); end
    n_checks++;
    if (s8(rd_obs) != "22 ") begin n_fail++; $display("FAIL read_bus: got '%s' expected '22 '", s8(rd_obs)); end
    n_checks++;
    if (s8(tx_obs) != "52 22 12 34 ") begin
      n_fail++; $display("FAIL read_tx: got '%s' expected '52 22 12 34 '", s8(tx_obs));
    end
    re_lat = (pop_cyc.size() == 2 && re_cyc.size() == 1) ? re_cyc[0] - pop_cyc[1] : -1;
    tx_lat = (re_cyc.size() == 1 && tx_cyc.size() > 0) ? tx_cyc[0] - re_cyc[0] : -1;
    n_checks++;
    if (re_lat != 1) begin n_fail++; $display("FAIL read_re_latency: got %0d expected 1", re_lat); end
    n_checks++;
    if (tx_lat != 2) begin n_fail++; $display("FAIL read_tx_latency: got %0d expected 2", tx_lat); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int gap;
    clear_obs();
    stall_at = 2;
    send('{8'h52, 8'h22});
    wait_idle(100, ok);
    stall_at = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_idle: got busy expected idle"); end
    n_checks++;
    if (s8(tx_obs) != "52 22 12 34 ") begin
      n_fail++; $display("FAIL bp_tx: got '%s' expected '52 22 12 34 '", s8(tx_obs));
    end
    gap = (tx_cyc.size() == 4) ? tx_cyc[2] - tx_cyc[1] : -1;
    n_checks++;
    if (gap != 6) begin n_fail++; $display("FAIL bp_stall_gap: got %0d expected 6", gap); end
    n_checks++;
    if (bad_push != 0) begin n_fail++; $display("FAIL bp_push_while_full: got %0d expected 0", bad_push); end
  endtask

  task automatic test_garbage();
    bit ok;
    clear_obs();
    send('{8'hFF, 8'h00, 8'h57, 8'h01, 8'h00, 8'h05});
    exp_err += 2;
    wait_idle(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL garbage_idle: got busy expected idle"); end
    n_checks++;
    if (err_count !== 8'(exp_err)) begin
      n_fail++; $display("FAIL garbage_err: got %0d expected %0d", err_count, exp_err);
    end
    n_checks++;
    if (s24(wr_obs) != "010005 ") begin
      n_fail++; $display("FAIL garbage_write: got '%s' expected '010005 '", s24(wr_obs));
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_obs();
    send('{8'h57, 8'h05});
    wait_drained(100, ok);
    tick(20);
    exp_err++;
    n_checks++;
    if (!ok || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got busy=%b expected 0", busy); end
    n_checks++;
    if (err_count !== 8'(exp_err)) begin
      n_fail++; $display("FAIL timeout_err: got %0d expected %0d", err_count, exp_err);
    end
    n_checks++;
    if (wr_obs.size() != 0) begin n_fail++; $display("FAIL timeout_no_we: got %0d writes expected 0", wr_obs.size()); end
    mem[8'h05] = 16'hBEEF;
    send('{8'h52, 8'h05});
    wait_idle(100, ok);
    n_checks++;
    if (s8(rd_obs) != "05 ") begin n_fail++; $display("FAIL timeout_next_rd: got '%s' expected '05 '", s8(rd_obs)); end
    n_checks++;
    if (s8(tx_obs) != "52 05 be ef ") begin
      n_fail++; $display("FAIL timeout_next_tx: got '%s' expected '52 05 be ef '", s8(tx_obs));
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    clear_obs();
    send('{8'h57, 8'h05, 8'hAA});
    wait_drained(100, ok);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_err = 0;
    n_checks++;
    if (!ok || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_checks++;
    if (err_count !== 8'h00) begin n_fail++; $display("FAIL rst_mid_err: got %0d expected 0", err_count); end
    n_checks++;
    if (reg_wdata !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_wdata: got %04h expected 0000", reg_wdata); end
    tick(3);
    n_checks++;
    if (wr_obs.size() != 0) begin n_fail++; $display("FAIL rst_mid_no_we: got %0d writes expected 0", wr_obs.size()); end
    send('{8'h57, 8'h33, 8'h12, 8'h34});
    wait_idle(100, ok);
    n_checks++;
    if (s24(wr_obs) != "331234 ") begin
      n_fail++; $display("FAIL rst_mid_next_write: got '%s' expected '331234 '", s24(wr_obs));
    end
  endtask

  // Packet-level reference: each random packet maps directly to its bus cycles and returned bytes.
  task automatic test_random();
    logic [15:0] ref_mem [256];
    logic [7:0]  exp_tx[$], exp_rd[$];
    logic [23:0] exp_wr[$];
    logic [7:0]  a, b;
    logic [15:0] d;
    bit          ok;
    clear_obs();
    ref_mem = mem;
    gap_en  = 1'b1;
    full_en = 1'b1;
    for (int p = 0; p < 30; p++) begin
      a = 8'($urandom);
      d = 16'($urandom);
      case ($urandom_range(2))
        0: begin
          send('{8'h57, a, d[15:8], d[7:0]});
          exp_wr.push_back({a, d});
          ref_mem[a] = d;
`ifdef FT_CMD_WRITE_ACK_EN
          exp_tx.push_back(8'h41);
          exp_tx.push_back(a);
`endif
        end
        1: begin
          send('{8'h52, a});
          exp_rd.push_back(a);
          exp_tx.push_back(8'h52);
          exp_tx.push_back(a);
          exp_tx.push_back(ref_mem[a][15:8]);
          exp_tx.push_back(ref_mem[a][7:0]);
        end
        default: begin
          do b = 8'($urandom); while (b == 8'h52 || b == 8'h57);
          send('{b});
          exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
      endcase
    end
    wait_idle(3000, ok);
    gap_en  = 1'b0;
    full_en = 1'b0;
    tick(2);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL random_idle: got busy expected idle"); end
    n_checks++;
    if (s24(wr_obs) != s24(exp_wr)) begin
      n_fail++; $display("FAIL random_writes: got '%s' expected '%s'", s24(wr_obs), s24(exp_wr));
    end
    n_checks++;
    if (s8(rd_obs) != s8(exp_rd)) begin
      n_fail++; $display("FAIL random_reads: got '%s' expected '%s'", s8(rd_obs), s8(exp_rd));
    end
    n_checks++;
    if (s8(tx_obs) != s8(exp_tx)) begin
      n_fail++; $display("FAIL random_tx: got '%s' expected '%s'", s8(tx_obs), s8(exp_tx));
    end
    n_checks++;
    if (err_count !== 8'(exp_err)) begin
      n_fail++; $display("FAIL random_err: got %0d expected %0d", err_count, exp_err);
    end
    n_checks++;
    if (bad_push != 0 || bad_pop != 0) begin
      n_fail++; $display("FAIL random_fifo_rules: got push_full=%0d pop_empty=%0d expected 0/0", bad_push, bad_pop);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    clear_obs();
    for (int i = 0; i < 300; i++) begin
      rxq.push_back(8'hFF);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    end
    wait_idle(600, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sat_idle: got busy expected idle"); end
    n_checks++;
    if (err_count !== 8'(exp_err)) begin
      n_fail++; $display("FAIL sat_err: got %0d expected %0d", err_count, exp_err);
    end
    n_checks++;
    if (wr_obs.size() != 0 || tx_obs.size() != 0) begin
      n_fail++; $display("FAIL sat_no_traffic: got %0d writes %0d tx expected 0/0", wr_obs.size(), tx_obs.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    tick(3);
    test_reset();
    rst = 1'b0;
    tick(2);
    test_write();
    test_read();
    test_backpressure();
    test_garbage();
    test_timeout();
    test_reset_mid_packet();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
